// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU, 2-cycle latency.
// Define ALU_ARB_FAIR_EN to add a starvation counter that forces grants to requester 1.
module alu_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [2:0]  req0_op,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   input  logic [2:0]  req1_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [2:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   input  logic        flush
);

   localparam logic [2:0] ALU_ADD = 3'd0;

   logic        accept0;
   logic        accept1;
   logic        force1;
   logic        issue_valid;
   logic        issue_id;
   logic [2:0]  issue_op;
   logic [15:0] issue_a;
   logic [15:0] issue_b;

   // The starvation counter is 3 bits wide, so the threshold has to fit in it.
   if (STARVE_MAX < 0 || STARVE_MAX > 7) begin : g_bad_starve_max
      $error("alu_arbiter: STARVE_MAX must be in 0..7");
   end

`ifdef ALU_ARB_FAIR_EN
   logic [2:0] starve_cnt;

   assign force1 = req1_valid && (starve_cnt == 3'(STARVE_MAX));

   // Counts consecutive cycles requester 1 waited; a flushed cycle leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!flush) begin
         if (req1_valid && !accept1) begin
            if (starve_cnt != 3'd7) begin
               starve_cnt <= starve_cnt + 3'd1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end
`else
   assign force1 = 1'b0;
`endif

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!flush) begin
         req0_ready = !force1;
         req1_ready = force1 || !req0_valid;
      end
   end

   assign accept0 = req0_valid && req0_ready;
   assign accept1 = req1_valid && req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         issue_id    <= 1'b0;
         issue_op    <= '0;
         issue_a     <= '0;
         issue_b     <= '0;
      end else begin
         issue_valid <= accept0 || accept1;
         if (accept0) begin
            issue_id <= 1'b0;
            issue_op <= req0_op;
            issue_a  <= req0_a;
            issue_b  <= req0_b;
         end else if (accept1) begin
            issue_id <= 1'b1;
            issue_op <= req1_op;
            issue_a  <= req1_a;
            issue_b  <= req1_b;
         end
      end
   end

   // An empty issue slot presents a harmless ADD of zeros to the ALU.
   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (issue_valid) begin
         alu_op = issue_op;
         alu_a  = issue_a;
         alu_b  = issue_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= issue_valid && !flush;
         if (issue_valid && !flush) begin
            rsp_id   <= issue_id;
            rsp_data <= alu_result;
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: cycles requester 1 may be denied before a forced grant (FAIR build only).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester 0 (EX stage) / requester 1 (auxiliary) has an operation.
REQ-005 SHALL have ports req0_op/req1_op  input  3  ALU opcode in the shared alu_ops encoding.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  operands.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-008 SHALL have ports alu_op  output  3, alu_a/alu_b  output  16  drive to the shared ALU.
REQ-009 SHALL have port alu_result  input  16  combinational ALU output.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_data  output  16  result return.
REQ-011 SHALL have port flush  input  1  synchronous kill of in-flight operations.

Function
REQ-012 SHALL grant at most one requester per cycle; readiness is combinational from valids and arbitration state.
REQ-013 SHALL, without the FAIR build, use strict priority: req0_ready=1 always; req1_ready = ~req0_valid.
REQ-014 SHALL latch the granted op, operands and id into an issue register at the accept edge (cycle N).
REQ-015 SHALL drive alu_op/alu_a/alu_b from the issue register during cycle N+1.
REQ-016 SHALL capture alu_result into rsp_data at the end of N+1 and assert rsp_valid with rsp_id for exactly one cycle (N+2); latency 2, throughput 1 op/cycle.
REQ-017 SHALL, when the issue register is empty, drive alu_op=ALU_ADD, alu_a=0, alu_b=0.
REQ-018 SHALL hold rsp_data at its last value while rsp_valid=0.
REQ-019 SHALL, when flush=1, clear issue and response valid bits at that edge, accept nothing that cycle (both readies 0), and not alter the starvation counter.
REQ-020 SHALL use no response backpressure; requesters must consume rsp_valid when presented.

Reset
REQ-021 SHALL on rst_n=0 immediately clear issue valid, rsp_valid, rsp_id, rsp_data, issue op/operands and starvation counter to 0, independent of clk.
REQ-022 SHALL drop any operation in flight when reset asserts mid-operation; no response is produced for it.
REQ-023 SHALL accept requests in the first cycle after rst_n deasserts.

Configuration
REQ-024 SHALL, with ALU_ARB_FAIR_EN defined, keep a 3-bit starvation counter: +1 each cycle req1_valid=1 and not granted (saturating), cleared when req1 is granted or req1_valid=0.
REQ-025 SHALL, with ALU_ARB_FAIR_EN defined, when counter == STARVE_MAX, grant req1 (req1_ready=1, req0_ready=0) that cycle.
REQ-026 SHALL, with ALU_ARB_FAIR_EN undefined, contain no counter and behave per REQ-013.

Verification
REQ-027 SHALL test: req0 ADD a=3,b=4 at cycle 1 alone -> cycle 3 rsp_valid=1, rsp_id=0, rsp_data=7.
REQ-028 SHALL test: both valid, req0 SUB 10-3, req1 XOR 0x00FF^0x0F0F -> req0 granted, rsp 7 (id 0); next cycle req0 idle -> req1 granted, rsp 0x0FF0 (id 1).
REQ-029 SHALL test back-to-back req0 ops each cycle for 8 cycles -> 8 consecutive rsp_valid pulses, in order, no gaps.
REQ-030 SHALL test: FAIR build, STARVE_MAX=4, both valid continuously -> req1 granted on the 5th cycle, then counter restarts; non-FAIR build -> req1 never granted.
REQ-031 SHALL test: accept at N, flush at N+1 -> no rsp_valid at N+2; rst_n low mid-stream -> all outputs 0 asynchronously, no stale response after release.
